// File: rtl/tlb_op_ctrl_if.sv
// TLB port bundle between the TLB-op controller (master) and the single-ported TLB (slave).
interface tlb_op_ctrl_if #(
    parameter int IDX_W = 5
);
    logic             req;
    logic             we;
    logic [IDX_W-1:0] idx;
    logic [31:0]      entryhi;
    logic [31:0]      pagemask;
    logic [31:0]      entrylo0;
    logic [31:0]      entrylo1;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [31:0]      rd_entryhi;
    logic [31:0]      rd_pagemask;
    logic [31:0]      rd_entrylo0;
    logic [31:0]      rd_entrylo1;

    modport master (
        output req, we, idx, entryhi, pagemask, entrylo0, entrylo1,
        input  hit, hit_idx, rd_entryhi, rd_pagemask, rd_entrylo0, rd_entrylo1
    );

    modport slave (
        input  req, we, idx, entryhi, pagemask, entrylo0, entrylo1,
        output hit, hit_idx, rd_entryhi, rd_pagemask, rd_entrylo0, rd_entrylo1
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR against a TLB port shared with data-side lookups.
// Optional TLB_OP_CTRL_PERF_EN adds retired-op and wait-cycle counters.
module tlb_op_ctrl #(
    parameter int IDX_W      = 5,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid_i,
    input  logic [2:0]       op_type_i,
    input  logic             flush_i,
    input  logic [31:0]      cp0_entryhi_i,
    input  logic [31:0]      cp0_pagemask_i,
    input  logic [31:0]      cp0_entrylo0_i,
    input  logic [31:0]      cp0_entrylo1_i,
    input  logic [IDX_W-1:0] cp0_index_i,
    input  logic [IDX_W-1:0] cp0_random_i,
    input  logic             dmmu_req_i,
    output logic             dmmu_gnt_o,
    tlb_op_ctrl_if.master    tlb,
    output logic [2:0]       tlb_type_o,
    output logic [31:0]      tlb_index_o,
    output logic [31:0]      tlb_entryhi_o,
    output logic [31:0]      tlb_pagemask_o,
    output logic [31:0]      tlb_entrylo0_o,
    output logic [31:0]      tlb_entrylo1_o,
    output logic             stall_o
`ifdef TLB_OP_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_ops_o,
    output logic [31:0]      perf_wait_o
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [2:0] OP_TLBP  = 3'b001;
    localparam logic [2:0] OP_TLBR  = 3'b010;
    localparam logic [2:0] OP_TLBWI = 3'b011;
    localparam logic [2:0] OP_TLBWR = 3'b100;

    localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [2:0]       state, state_nxt;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] starve_cnt;
    logic             starved, op_gnt, op_legal, is_write, in_access;

    assign starved   = (starve_cnt == STARVE_LIM);
    assign op_gnt    = ~dmmu_req_i | starved;
    assign op_legal  = (op_type_i inside {OP_TLBP, OP_TLBR, OP_TLBWI, OP_TLBWR});
    assign is_write  = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);
    assign in_access = (state == S_ACCESS);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (op_valid_i && op_legal && !flush_i)
                          state_nxt = op_gnt ? S_ACCESS : S_WAIT;
            S_WAIT:   if (flush_i)     state_nxt = S_IDLE;
                      else if (op_gnt) state_nxt = S_ACCESS;
            S_ACCESS: if (flush_i)     state_nxt = S_IDLE;
                      else             state_nxt = is_write ? S_DONE : S_RESP;
            S_RESP:   state_nxt = flush_i ? S_IDLE : S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            op_q       <= 3'b000;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE)
                op_q <= op_type_i;
            if (state == S_WAIT && state_nxt == S_WAIT)
                starve_cnt <= starved ? starve_cnt : starve_cnt + CNT_W'(1);
            else
                starve_cnt <= '0;
        end
    end

    // Results are captured in the cycle after the port access; a flush drops them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tlb_index_o    <= 32'h8000_0000;
            tlb_entryhi_o  <= '0;
            tlb_pagemask_o <= '0;
            tlb_entrylo0_o <= '0;
            tlb_entrylo1_o <= '0;
        end else if (state == S_RESP && !flush_i) begin
            if (op_q == OP_TLBP) begin
                if (tlb.hit)
                    tlb_index_o <= {1'b0, {(31-IDX_W){1'b0}}, tlb.hit_idx};
                else
                    tlb_index_o[31] <= 1'b1;
            end
            if (op_q == OP_TLBR) begin
                tlb_entryhi_o  <= tlb.rd_entryhi;
                tlb_pagemask_o <= tlb.rd_pagemask;
                tlb_entrylo0_o <= tlb.rd_entrylo0;
                tlb_entrylo1_o <= tlb.rd_entrylo1;
            end
        end
    end

    assign tlb.req      = in_access && (op_q == OP_TLBP || op_q == OP_TLBR);
    assign tlb.we       = in_access && is_write && !flush_i;
    assign tlb.idx      = !in_access            ? '0 :
                          (op_q == OP_TLBWR)    ? cp0_random_i :
                          (op_q == OP_TLBP)     ? '0 : cp0_index_i;
    assign tlb.entryhi  = cp0_entryhi_i;
    assign tlb.pagemask = cp0_pagemask_i;
    assign tlb.entrylo0 = cp0_entrylo0_i;
    assign tlb.entrylo1 = cp0_entrylo1_i;

    assign tlb_type_o = (state != S_DONE)  ? 3'b000 :
                        (op_q == OP_TLBP)  ? 3'b001 :
                        (op_q == OP_TLBR)  ? 3'b010 : 3'b000;

    // Outputs driven straight from inputs are gated by rst so they also read 0 during reset.
    assign stall_o    = rst && op_valid_i && op_legal && (state != S_DONE) && !flush_i;
    assign dmmu_gnt_o = rst && dmmu_req_i && !in_access && !(state == S_WAIT && starved);

`ifdef TLB_OP_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_ops_o  <= '0;
            perf_wait_o <= '0;
        end else begin
            perf_ops_o  <= perf_ops_o  + 32'(state == S_DONE);
            perf_wait_o <= perf_wait_o + 32'(state == S_WAIT);
        end
    end
`endif

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: expected results queued at issue, compared at retirement.
module tb_tlb_op_ctrl;
    localparam int IDX_W      = 5;
    localparam int STARVE_MAX = 8;

    localparam logic [2:0] OP_TLBP  = 3'b001;
    localparam logic [2:0] OP_TLBR  = 3'b010;
    localparam logic [2:0] OP_TLBWI = 3'b011;
    localparam logic [2:0] OP_TLBWR = 3'b100;

    logic             clk, rst;
    logic             op_valid, flush, dmmu_req, dmmu_gnt, stall;
    logic [2:0]       op_type, tlb_type;
    logic [31:0]      cp0_entryhi, cp0_pagemask, cp0_entrylo0, cp0_entrylo1;
    logic [IDX_W-1:0] cp0_index, cp0_random;
    logic [31:0]      tlb_index, tlb_entryhi, tlb_pagemask, tlb_entrylo0, tlb_entrylo1;
`ifdef TLB_OP_CTRL_PERF_EN
    logic [31:0]      perf_ops, perf_wait;
`endif

    tlb_op_ctrl_if #(.IDX_W(IDX_W)) tlb_bus ();

    tlb_op_ctrl #(.IDX_W(IDX_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk            (clk),
        .rst            (rst),
        .op_valid_i     (op_valid),
        .op_type_i      (op_type),
        .flush_i        (flush),
        .cp0_entryhi_i  (cp0_entryhi),
        .cp0_pagemask_i (cp0_pagemask),
        .cp0_entrylo0_i (cp0_entrylo0),
        .cp0_entrylo1_i (cp0_entrylo1),
        .cp0_index_i    (cp0_index),
        .cp0_random_i   (cp0_random),
        .dmmu_req_i     (dmmu_req),
        .dmmu_gnt_o     (dmmu_gnt),
        .tlb            (tlb_bus),
        .tlb_type_o     (tlb_type),
        .tlb_index_o    (tlb_index),
        .tlb_entryhi_o  (tlb_entryhi),
        .tlb_pagemask_o (tlb_pagemask),
        .tlb_entrylo0_o (tlb_entrylo0),
        .tlb_entrylo1_o (tlb_entrylo1),
        .stall_o        (stall)
`ifdef TLB_OP_CTRL_PERF_EN
        ,
        .perf_ops_o     (perf_ops),
        .perf_wait_o    (perf_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] index, ehi, pm, lo0, lo1;
        int          done_k;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Model of the registered result outputs
    logic [31:0] m_index, m_ehi, m_pm, m_lo0, m_lo1;
    // TLB responder contents for the current op
    logic             r_hit;
    logic [IDX_W-1:0] r_hidx;
    logic [31:0]      r_data [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Response is valid only in the cycle after a request; otherwise drive distinct junk.
    task automatic drive_resp(input bit valid);
        tlb_bus.hit         = valid ? r_hit  : ~r_hit;
        tlb_bus.hit_idx     = valid ? r_hidx : ~r_hidx;
        tlb_bus.rd_entryhi  = valid ? r_data[0] : 32'hdead_beef;
        tlb_bus.rd_pagemask = valid ? r_data[1] : 32'hdead_beef;
        tlb_bus.rd_entrylo0 = valid ? r_data[2] : 32'hdead_beef;
        tlb_bus.rd_entrylo1 = valid ? r_data[3] : 32'hdead_beef;
    endtask

    task automatic model_reset();
        m_index = 32'h8000_0000;
        m_ehi = '0; m_pm = '0; m_lo0 = '0; m_lo1 = '0;
    endtask

    task automatic run_op(input logic [2:0] op, input bit dmmu, input bit hit,
                          input logic [IDX_W-1:0] hidx);
        exp_t        e;
        bit          wr, prev_req, done;
        int          acc_k;
        logic [31:0] exp_idx;
        wr    = (op == OP_TLBWI) || (op == OP_TLBWR);
        acc_k = dmmu ? STARVE_MAX + 2 : 1;
        r_hit = hit; r_hidx = hidx;
        for (int i = 0; i < 4; i++) r_data[i] = $urandom;
        if (op == OP_TLBP)
            m_index = hit ? {27'b0, hidx} : (m_index | 32'h8000_0000);
        if (op == OP_TLBR) begin
            m_ehi = r_data[0]; m_pm = r_data[1]; m_lo0 = r_data[2]; m_lo1 = r_data[3];
        end
        e.typ    = (op == OP_TLBP) ? 3'b001 : (op == OP_TLBR) ? 3'b010 : 3'b000;
        e.index  = m_index; e.ehi = m_ehi; e.pm = m_pm; e.lo0 = m_lo0; e.lo1 = m_lo1;
        e.done_k = acc_k + (wr ? 1 : 2);
        sb.push_back(e);
        exp_idx = (op == OP_TLBWR) ? 32'(cp0_random) : 32'(cp0_index);

        @(negedge clk);
        op_valid = 1'b1; op_type = op; dmmu_req = dmmu;
        drive_resp(1'b0);
        #1;
        check("stall_issue", stall, 1);
        check("gnt_issue", dmmu_gnt, dmmu);
        prev_req = 1'b0;
        done     = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            drive_resp(prev_req);
            prev_req = tlb_bus.req;
            #1;
            check("req", tlb_bus.req, (k == acc_k) && !wr);
            check("we", tlb_bus.we, (k == acc_k) && wr);
            if (k == acc_k && op != OP_TLBP) check("idx", tlb_bus.idx, exp_idx);
            if (k == acc_k && op == OP_TLBP) check("key", tlb_bus.entryhi, cp0_entryhi);
            check("gnt", dmmu_gnt, dmmu && k != acc_k && k != acc_k - 1);
            if (!stall) begin
                e = sb.pop_front();
                check("latency", k, e.done_k);
                check("type", tlb_type, e.typ);
                check("index", tlb_index, e.index);
                check("entryhi", tlb_entryhi, e.ehi);
                check("pagemask", tlb_pagemask, e.pm);
                check("entrylo0", tlb_entrylo0, e.lo0);
                check("entrylo1", tlb_entrylo1, e.lo1);
                done = 1'b1;
            end else begin
                check("no_pulse", tlb_type, 0);
            end
        end
        if (!done) begin
            check("timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        op_valid = 1'b0; dmmu_req = 1'b0;
        @(negedge clk);
        #1;
        check("pulse_end", tlb_type, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_gnt"}, dmmu_gnt, 0);
        check({tag, "_req"}, tlb_bus.req, 0);
        check({tag, "_we"}, tlb_bus.we, 0);
        check({tag, "_type"}, tlb_type, 0);
        check({tag, "_index"}, tlb_index, 32'h8000_0000);
        check({tag, "_entryhi"}, tlb_entryhi, 0);
        check({tag, "_entrylo1"}, tlb_entrylo1, 0);
    endtask

    initial begin
        rst = 1'b0; op_valid = 1'b0; op_type = 3'b000; flush = 1'b0; dmmu_req = 1'b1;
        cp0_entryhi = 32'h0040_0000; cp0_pagemask = 32'h0000_6000;
        cp0_entrylo0 = 32'h0000_1f07; cp0_entrylo1 = 32'h0000_2f07;
        cp0_index = 5'd9; cp0_random = 5'd17;
        r_hit = 1'b0; r_hidx = '0;
        for (int i = 0; i < 4; i++) r_data[i] = '0;
        drive_resp(1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        dmmu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_op(OP_TLBP,  1'b0, 1'b1, 5'd5);     // hit at index 5
        run_op(OP_TLBP,  1'b0, 1'b0, 5'd22);    // miss keeps old index field
        run_op(OP_TLBWR, 1'b0, 1'b0, 5'd0);     // write at Random = 17
        run_op(OP_TLBWI, 1'b0, 1'b0, 5'd0);     // write at Index = 9
        run_op(OP_TLBR,  1'b1, 1'b0, 5'd0);     // starved read, forced grant
        run_op(OP_TLBR,  1'b0, 1'b0, 5'd0);
        run_op(OP_TLBP,  1'b1, 1'b1, 5'd12);    // starved probe

        // Illegal type retires immediately
        @(negedge clk);
        op_valid = 1'b1; op_type = 3'b111;
        #1;
        check("illegal_stall", stall, 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("illegal_port", {tlb_bus.req, tlb_bus.we}, 0);
            check("illegal_type", tlb_type, 0);
        end
        op_valid = 1'b0;

        // Flush during ACCESS of TLBWI suppresses the write
        @(negedge clk);
        op_valid = 1'b1; op_type = OP_TLBWI;
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_acc_we", tlb_bus.we, 0);
        check("flush_acc_stall", stall, 0);
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        #1;
        check("flush_acc_type", tlb_type, 0);
        check("flush_acc_port", {tlb_bus.req, tlb_bus.we}, 0);

        // Flush during RESP of TLBP: no pulse
        r_hit = 1'b1; r_hidx = 5'd3;
        @(negedge clk);
        op_valid = 1'b1; op_type = OP_TLBP;
        @(negedge clk);
        @(negedge clk);
        drive_resp(1'b1);
        flush = 1'b1;
        #1;
        check("flush_resp_stall", stall, 0);
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        #1;
        check("flush_resp_type", tlb_type, 0);

        // Reset asserted in RESP of a TLBR
        for (int i = 0; i < 4; i++) r_data[i] = $urandom | 32'h1;
        @(negedge clk);
        op_valid = 1'b1; op_type = OP_TLBR;
        @(negedge clk);
        @(negedge clk);
        drive_resp(1'b1);
        rst = 1'b0; dmmu_req = 1'b1;
        #1;
        check_reset_outputs("rst_resp");
        model_reset();
        op_valid = 1'b0; dmmu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Reset asserted in WAIT, then a full starved op must see a fresh counter
        @(negedge clk);
        op_valid = 1'b1; op_type = OP_TLBR; dmmu_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("wait_gnt", dmmu_gnt, 1);
        check("wait_stall", stall, 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        op_valid = 1'b0; dmmu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op(OP_TLBR, 1'b1, 1'b0, 5'd0);
        run_op(OP_TLBP, 1'b0, 1'b0, 5'd7);      // miss after reset -> 0x80000000

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
